fsk_tone_sequencer: RTL and testbench
=====================================

Name: fsk_tone_sequencer

Overview:
- Bit-level controller for the FSK divider datapath. Accepts a serial bit stream over a valid/ready handshake and holds each bit for a fixed number of clocks.
- For each bit it drives the divider count value: mark base for 1, space base for 0.
- Fractional-N dithering alternates the count value between base and base+1 on divider rollovers, so mean tone frequency is set finer than one count step.
- Sits between the framing logic (bit source) and the programmable divider/NCO (count_value consumer).

Parameters:
- CNT_W, 32, width of count_value.
- FRAC_W, 4, width of the dither phase accumulator and fraction constants.
- MARK_DIV, 98, integer count value for bit 1.
- MARK_FRAC, 8, fractional part for bit 1, in units of 1/2^FRAC_W (8 gives 98.5 mean).
- SPACE_DIV, 120, integer count value for bit 0.
- SPACE_FRAC, 0, fractional part for bit 0.
- IDLE_DIV, 98, count value driven while idle.
- BIT_CYCLES, 1000, clocks per bit. Must be >= 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  run request. Sampled each cycle.
- bit_valid  in  1  bit_data valid.
- bit_data  in  1  bit to transmit (1 = mark, 0 = space).
- bit_ready  out  1  sequencer accepts bit_data this cycle.
- div_tick  in  1  one-cycle strobe from the divider at each output-period rollover.
- count_value  out  CNT_W  divider reload value.
- tone_active  out  1  high while a bit is being held.
- underrun  out  1  one-cycle pulse when the bit source starved mid-stream.

Behaviour:
- Reset values (asynchronous): state=IDLE, count_value=IDLE_DIV, tone_active=0, underrun=0, dwell=0, acc=0, cur_bit=0. bit_ready is combinational from state, so it is 0 during reset.
- Handshake: a transfer happens when bit_valid & bit_ready are both high at a rising edge. bit_data is captured only on a transfer. The source must hold bit_valid/bit_data until the transfer.
- bit_ready:
  - IDLE: bit_ready = enable.
  - TONE: bit_ready = enable & (dwell==0).
  - Never high in any other case.
- State IDLE:
  - count_value=IDLE_DIV, tone_active=0, acc held at 0.
  - On a transfer: cur_bit<=bit_data, dwell<=BIT_CYCLES-1, acc<=0, count_value<=selected base (MARK_DIV or SPACE_DIV), tone_active<=1, go to TONE.
  - Latency: new count_value is visible on the cycle after the transfer edge.
- State TONE:
  - dwell decrements by 1 each cycle while nonzero.
  - div_tick with dwell!=0: {carry,acc} <= acc + frac(cur_bit) in FRAC_W+1 bits; count_value <= base(cur_bit) + carry. Zero-extend to CNT_W; parameters guarantee base+1 < 2^CNT_W.
- Bit boundary (TONE, dwell==0):
  - Transfer occurs: load the new bit exactly as from IDLE. Back-to-back bits have no gap: each bit lasts exactly BIT_CYCLES clocks.
  - enable=1 and bit_valid=0: underrun<=1 for one cycle, go to IDLE (count_value<=IDLE_DIV, tone_active<=0).
  - enable=0: go to IDLE, no underrun.
- Simultaneous events:
  - div_tick at the same edge as a bit load: the load wins. acc restarts at 0 and count_value = new base, with no carry applied.
  - enable falling mid-bit: the current bit completes its full BIT_CYCLES. No truncation.
- Fraction 0: count_value stays constant at base for the whole bit. acc never carries.
- acc wraps modulo 2^FRAC_W. Carry sets +1 for exactly the period following that tick.
- bit_data is ignored when no transfer occurs. div_tick in IDLE is ignored.
- Reset mid-TONE: immediate return to reset values. The bit in flight is lost and no underrun is flagged.

Decomposition:
- Shared package fsk_pkg:
  - state enum (IDLE, TONE).
  - default constants MARK_DIV/SPACE_DIV/IDLE_DIV/BIT_CYCLES, shared with the divider and demodulator blocks so tone plans stay consistent.
- One sub-module: fsk_frac_dither. Holds acc, add, carry and the base+carry output. Controls: clear, step (div_tick) and base/frac select. Reused for any future fractional divider settings.

Test Plan:
- Reset then single bit 1 (BIT_CYCLES=8, enable=1): transfer at cycle T -> count_value=98 from T+1; tone_active high T+1..T+8; then underrun pulse at T+9 and count_value=98 (IDLE_DIV).
- Dither check, bit 1 with MARK_FRAC=8, div_tick every cycle -> count_value sequence 98,99,98,99... (carry on every 2nd tick); bit 0 with SPACE_FRAC=0 -> steady 120.
- Back-to-back stream 1,0,1 with bit_valid always high -> bit_ready high only at dwell==0; count_value switches 98->120->98 at exact 8-cycle spacing; no underrun.
- enable dropped at cycle 3 of a bit -> bit completes all 8 cycles, then IDLE with count_value=98 and no underrun; bit_ready stays 0.
- div_tick coincident with a bit-load edge -> count_value equals the new base (120), acc=0, no +1 applied.
- Assert rst at cycle 4 of a bit -> count_value=98, tone_active=0, bit_ready=0 immediately (asynchronous); after release, a fresh bit loads normally.

Source files
------------

// File: rtl/fsk_pkg.sv
// Shared FSK definitions: sequencer state encoding and the default tone plan
// used by the divider, demodulator and sequencer blocks.
package fsk_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    TONE = 1'b1
  } state_e;

  localparam int FSK_MARK_DIV   = 98;
  localparam int FSK_MARK_FRAC  = 8;
  localparam int FSK_SPACE_DIV  = 120;
  localparam int FSK_SPACE_FRAC = 0;
  localparam int FSK_IDLE_DIV   = 98;
  localparam int FSK_BIT_CYCLES = 1000;

endpackage

// File: rtl/fsk_frac_dither.sv
// Fractional-N dither: a FRAC_W-bit phase accumulator whose carry bumps the
// selected base count by one for the divider period following a step.
module fsk_frac_dither
  import fsk_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int FRAC_W     = 4,
  parameter int MARK_DIV   = FSK_MARK_DIV,
  parameter int MARK_FRAC  = FSK_MARK_FRAC,
  parameter int SPACE_DIV  = FSK_SPACE_DIV,
  parameter int SPACE_FRAC = FSK_SPACE_FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             step_i,
  input  logic             sel_i,
  output logic [CNT_W-1:0] count_o
);

  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W-1:0] frac;
  logic [FRAC_W:0]   sum;
  logic [CNT_W-1:0]  base;

  assign frac    = sel_i ? FRAC_W'(MARK_FRAC) : FRAC_W'(SPACE_FRAC);
  assign base    = sel_i ? CNT_W'(MARK_DIV) : CNT_W'(SPACE_DIV);
  assign sum     = {1'b0, acc_q} + {1'b0, frac};
  // count_o is only meaningful as the value to load on a step edge
  assign count_o = base + CNT_W'(sum[FRAC_W]);

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (step_i) begin
      acc_d = sum[FRAC_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/fsk_tone_sequencer.sv
// Bit-level FSK controller: accepts serial bits over valid/ready, holds each
// for BIT_CYCLES clocks and drives the (dithered) divider reload value.
module fsk_tone_sequencer
  import fsk_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int FRAC_W     = 4,
  parameter int MARK_DIV   = FSK_MARK_DIV,
  parameter int MARK_FRAC  = FSK_MARK_FRAC,
  parameter int SPACE_DIV  = FSK_SPACE_DIV,
  parameter int SPACE_FRAC = FSK_SPACE_FRAC,
  parameter int IDLE_DIV   = FSK_IDLE_DIV,
  parameter int BIT_CYCLES = FSK_BIT_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             bit_valid,
  input  logic             bit_data,
  output logic             bit_ready,
  input  logic             div_tick,
  output logic [CNT_W-1:0] count_value,
  output logic             tone_active,
  output logic             underrun
);

  localparam int DW_W = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;

  state_e            state_q;
  logic [DW_W-1:0]   dwell_q;
  logic              cur_bit_q;
  logic [CNT_W-1:0]  count_value_q;
  logic              tone_active_q;
  logic              underrun_q;

  logic              dwell_zero;
  logic              xfer;
  logic              dither_step;
  logic              dither_clear;
  logic [CNT_W-1:0]  dither_count;
  logic [CNT_W-1:0]  load_base;

  assign dwell_zero   = (dwell_q == '0);
  assign bit_ready    = !rst && enable && ((state_q == IDLE) || dwell_zero);
  assign xfer         = bit_valid && bit_ready;
  assign dither_step  = (state_q == TONE) && !dwell_zero && div_tick;
  // Leaving a bit (either to a new bit or to idle) always restarts the phase
  assign dither_clear = (state_q == IDLE) || dwell_zero;
  assign load_base    = bit_data ? CNT_W'(MARK_DIV) : CNT_W'(SPACE_DIV);

  fsk_frac_dither #(
    .CNT_W      (CNT_W),
    .FRAC_W     (FRAC_W),
    .MARK_DIV   (MARK_DIV),
    .MARK_FRAC  (MARK_FRAC),
    .SPACE_DIV  (SPACE_DIV),
    .SPACE_FRAC (SPACE_FRAC)
  ) u_dither (
    .clk     (clk),
    .rst     (rst),
    .clear_i (dither_clear),
    .step_i  (dither_step),
    .sel_i   (cur_bit_q),
    .count_o (dither_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      dwell_q       <= '0;
      cur_bit_q     <= 1'b0;
      count_value_q <= CNT_W'(IDLE_DIV);
      tone_active_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      if (xfer) begin
        // A load always wins over a coincident div_tick: no carry applied
        state_q       <= TONE;
        cur_bit_q     <= bit_data;
        dwell_q       <= DW_W'(BIT_CYCLES - 1);
        count_value_q <= load_base;
        tone_active_q <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
            count_value_q <= CNT_W'(IDLE_DIV);
            tone_active_q <= 1'b0;
          end
          TONE: begin
            if (!dwell_zero) begin
              dwell_q <= dwell_q - DW_W'(1);
              if (div_tick) begin
                count_value_q <= dither_count;
              end
            end else begin
              state_q       <= IDLE;
              count_value_q <= CNT_W'(IDLE_DIV);
              tone_active_q <= 1'b0;
              underrun_q    <= enable;
            end
          end
        endcase
      end
    end
  end

  assign count_value = count_value_q;
  assign tone_active = tone_active_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_fsk_tone_sequencer.sv
// Self-checking bench for fsk_tone_sequencer: directed scenarios plus a long
// randomized run, all compared cycle by cycle against a behavioural model.
module tb_fsk_tone_sequencer;

  localparam int B          = 8;
  localparam int MARK       = 98;
  localparam int MARK_FR    = 8;
  localparam int SPACE      = 120;
  localparam int SPACE_FR   = 0;
  localparam int IDLE_CNT   = 98;
  localparam int FRAC_MOD   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        bit_valid;
  logic        bit_data;
  logic        bit_ready;
  logic        div_tick;
  logic [31:0] count_value;
  logic        tone_active;
  logic        underrun;

  always #5 clk = ~clk;

  fsk_tone_sequencer #(
    .CNT_W      (32),
    .FRAC_W     (4),
    .MARK_DIV   (MARK),
    .MARK_FRAC  (MARK_FR),
    .SPACE_DIV  (SPACE),
    .SPACE_FRAC (SPACE_FR),
    .IDLE_DIV   (IDLE_CNT),
    .BIT_CYCLES (B)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .bit_valid   (bit_valid),
    .bit_data    (bit_data),
    .bit_ready   (bit_ready),
    .div_tick    (div_tick),
    .count_value (count_value),
    .tone_active (tone_active),
    .underrun    (underrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural model: a bit in progress, how many of its clocks have elapsed,
  // and the fractional phase as a plain integer modulo 2^FRAC_W.
  bit m_busy;
  int m_elapsed;
  bit m_bit;
  int m_phase;
  int m_cnt;
  bit m_tone;
  bit m_und;

  function automatic int base_of(bit b);
    return b ? MARK : SPACE;
  endfunction

  function automatic int frac_of(bit b);
    return b ? MARK_FR : SPACE_FR;
  endfunction

  function automatic void m_reset();
    m_busy = 0; m_elapsed = 0; m_bit = 0; m_phase = 0;
    m_cnt = IDLE_CNT; m_tone = 0; m_und = 0;
  endfunction

  function automatic void m_start(bit b);
    m_busy = 1; m_elapsed = 0; m_bit = b; m_phase = 0;
    m_cnt = base_of(b); m_tone = 1;
  endfunction

  function automatic void m_edge(bit xfer, bit d, bit t, bit en);
    int s;
    m_und = 0;
    if (!m_busy) begin
      if (xfer) m_start(d);
    end else if (m_elapsed < B - 1) begin
      m_elapsed++;
      if (t) begin
        s       = m_phase + frac_of(m_bit);
        m_phase = s % FRAC_MOD;
        m_cnt   = base_of(m_bit) + ((s >= FRAC_MOD) ? 1 : 0);
      end
    end else if (xfer) begin
      m_start(d);
    end else begin
      m_busy = 0; m_tone = 0; m_cnt = IDLE_CNT; m_und = en;
    end
  endfunction

  bit src_q[$];
  int tone_seen;
  int und_seen;

  // One clock: drive at negedge, check ready, advance model at posedge, check outputs.
  task automatic step_cycle(input bit en, input bit t);
    bit v, d, rdy, x;
    @(negedge clk);
    v = (src_q.size() > 0);
    d = v ? src_q[0] : bit'($urandom_range(1, 0));
    enable = en; bit_valid = v; bit_data = d; div_tick = t;
    #1;
    rdy = en && (!m_busy || m_elapsed == B - 1);
    check_eq("bit_ready", bit_ready, rdy);
    x = v && rdy;
    if (x) void'(src_q.pop_front());
    @(posedge clk);
    m_edge(x, d, t, en);
    #1;
    check_eq("count_value", count_value, m_cnt);
    check_eq("tone_active", tone_active, m_tone);
    check_eq("underrun", underrun, m_und);
    tone_seen += tone_active;
    und_seen  += underrun;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; bit_valid = 1'b0; bit_data = 1'b0; div_tick = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    check_eq("reset_count", count_value, IDLE_CNT);
    check_eq("reset_tone", tone_active, 0);
    check_eq("reset_underrun", underrun, 0);
    check_eq("reset_ready", bit_ready, 0);
    rst = 1'b0;

    // Single mark bit then starvation
    tone_seen = 0; und_seen = 0;
    src_q.push_back(1'b1);
    repeat (11) step_cycle(1, 0);
    check_eq("single_tone_len", tone_seen, B);
    check_eq("single_underrun", und_seen, 1);

    // Dither on mark, then space loaded on a tick edge
    src_q.push_back(1'b1);
    step_cycle(1, 1);
    check_eq("dither_load", count_value, MARK);
    for (int i = 0; i < B - 1; i++) begin
      step_cycle(1, 1);
      check_eq("dither_seq", count_value, (i % 2) ? MARK + 1 : MARK);
    end
    src_q.push_back(1'b0);
    step_cycle(1, 1);
    check_eq("tick_at_load", count_value, SPACE);
    for (int i = 0; i < B - 1; i++) begin
      step_cycle(1, 1);
      check_eq("space_steady", count_value, SPACE);
    end
    step_cycle(1, 0);

    // Back-to-back 1,0,1
    und_seen = 0;
    src_q.push_back(1'b1); src_q.push_back(1'b0); src_q.push_back(1'b1);
    for (int i = 0; i < 3 * B; i++) begin
      step_cycle(1, 0);
      if (i % B == 0) check_eq("b2b_base", count_value, (i == B) ? SPACE : MARK);
    end
    check_eq("b2b_no_underrun", und_seen, 0);
    step_cycle(1, 0);

    // Enable dropped mid-bit while another bit waits
    tone_seen = 0; und_seen = 0;
    src_q.push_back(1'b0);
    repeat (3) step_cycle(1, 0);
    src_q.push_back(1'b1);
    repeat (10) step_cycle(0, 0);
    check_eq("drop_tone_len", tone_seen, B);
    check_eq("drop_underrun", und_seen, 0);
    check_eq("drop_idle_count", count_value, IDLE_CNT);

    // Asynchronous reset mid-bit
    src_q.delete();
    src_q.push_back(1'b0);
    repeat (4) step_cycle(1, 0);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_count", count_value, IDLE_CNT);
    check_eq("arst_tone", tone_active, 0);
    check_eq("arst_ready", bit_ready, 0);
    m_reset();
    src_q.delete();
    @(negedge clk);
    rst = 1'b0;
    src_q.push_back(1'b0);
    repeat (3) step_cycle(1, 0);
    check_eq("post_reset_load", count_value, SPACE);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (src_q.size() < 2 && $urandom_range(3, 0) == 0) src_q.push_back(bit'($urandom_range(1, 0)));
      step_cycle(($urandom_range(15, 0) != 0), ($urandom_range(2, 0) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
